// File: rtl/div_share_arbiter.sv
// Round-robin arbiter that shares one iterative divider between NUM_REQ requesters.
// Divide-by-zero is answered locally; a hung divider is aborted after TIMEOUT cycles.
module div_share_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
   input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
   output logic [NUM_REQ-1:0]       rsp_valid,
   input  logic [NUM_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]         rsp_quotient,
   output logic [WIDTH-1:0]         rsp_remainder,
   output logic                     rsp_divzero,
   output logic                     rsp_error,
   output logic                     div_start,
   output logic                     div_abort,
   output logic [WIDTH-1:0]         div_dividend,
   output logic [WIDTH-1:0]         div_divisor,
   input  logic                     div_done,
   input  logic [WIDTH-1:0]         div_quotient,
   input  logic [WIDTH-1:0]         div_remainder
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state, state_n;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    grant;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] op_a, op_b;
   logic [WIDTH-1:0] res_q, res_r;
   logic             res_dz, res_er;

   logic             win_ok;
   logic [IW-1:0]    win;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic             abort;

   // Search starts at rr_ptr and wraps, so the last winner gets lowest priority.
   always_comb begin
      win_ok = 1'b0;
      win    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int j;
         j = (int'(rr_ptr) + i) % NUM_REQ;
         if (!win_ok && req_valid[j]) begin
            win_ok = 1'b1;
            win    = IW'(j);
         end
      end
   end

   assign sel_a = req_dividend[win*WIDTH +: WIDTH];
   assign sel_b = req_divisor[win*WIDTH +: WIDTH];

   always_comb begin
      state_n = state;
      abort   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (win_ok)
               state_n = (sel_b == '0) ? S_RESP : S_ISSUE;
         end
         S_ISSUE: state_n = S_WAIT;
         S_WAIT: begin
            if (div_done) begin
               state_n = S_RESP;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               abort   = 1'b1;
               state_n = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready[grant])
               state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         rr_ptr <= '0;
         grant  <= '0;
         cnt    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         res_q  <= '0;
         res_r  <= '0;
         res_dz <= 1'b0;
         res_er <= 1'b0;
      end else begin
         state <= state_n;
         if (state == S_IDLE && win_ok) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            grant  <= win;
            rr_ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            if (sel_b == '0) begin
               res_q  <= '1;
               res_r  <= sel_a;
               res_dz <= 1'b1;
               res_er <= 1'b0;
            end
         end
         if (state == S_ISSUE)
            cnt <= '0;
         // Done has priority over a coinciding timeout.
         if (state == S_WAIT) begin
            cnt <= cnt + 1'b1;
            if (div_done) begin
               res_q  <= div_quotient;
               res_r  <= div_remainder;
               res_dz <= 1'b0;
               res_er <= 1'b0;
            end else if (abort) begin
               res_q  <= '0;
               res_r  <= '0;
               res_dz <= 1'b0;
               res_er <= 1'b1;
            end
         end
      end
   end

   // The state register idles in S_IDLE during reset; gate so ready reads 0.
   assign req_ready = (rst_n && state == S_IDLE && win_ok)
                    ? (NUM_REQ'(1) << win) : '0;
   assign rsp_valid = (state == S_RESP) ? (NUM_REQ'(1) << grant) : '0;

   assign rsp_quotient  = res_q;
   assign rsp_remainder = res_r;
   assign rsp_divzero   = res_dz;
   assign rsp_error     = res_er;
   assign div_start     = (state == S_ISSUE);
   assign div_abort     = abort;
   assign div_dividend  = op_a;
   assign div_divisor   = op_b;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter: directed requests, a latency-programmable
// divider model, and a monitor that checks each response against queued expectations.
module tb_div_share_arbiter;

   localparam int N  = 2;
   localparam int W  = 32;
   localparam int TO = 64;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_dividend;
   logic [N*W-1:0] req_divisor;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready;
   logic [W-1:0]   rsp_quotient;
   logic [W-1:0]   rsp_remainder;
   logic           rsp_divzero;
   logic           rsp_error;
   logic           div_start;
   logic           div_abort;
   logic [W-1:0]   div_dividend;
   logic [W-1:0]   div_divisor;
   logic           div_done;
   logic [W-1:0]   div_quotient;
   logic [W-1:0]   div_remainder;

   div_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
      .rsp_divzero(rsp_divzero), .rsp_error(rsp_error),
      .div_start(div_start), .div_abort(div_abort),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_done(div_done), .div_quotient(div_quotient),
      .div_remainder(div_remainder)
   );

   typedef struct {
      logic [W-1:0] a, b, q, r;
      logic         dz, er;
      int           lat;
      bit           lost;
      int           k;
      int           acc;
   } ent_t;

   ent_t reqq[N][$];
   ent_t sb[$];
   int   grant_log[$];
   ent_t cur;
   bit   in_rsp;

   int n_chk, n_fail;
   int cyc, last_acc_cyc, start_cnt, abort_cnt;

   int           lat;
   logic         late_done, done_m;
   logic [W-1:0] q_m, r_m;
   int           rem;
   bit           busy;

   assign div_done      = done_m | late_done;
   assign div_quotient  = q_m;
   assign div_remainder = r_m;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic ent_t mk(input logic [W-1:0] a, b, q, r,
                               input logic dz, er, input int lt,
                               input bit lost = 1'b0);
      ent_t e;
      e.a = a; e.b = b; e.q = q; e.r = r;
      e.dz = dz; e.er = er; e.lat = lt; e.lost = lost;
      e.k = 0; e.acc = 0;
      return e;
   endfunction

   // Divider model: done pulses lat cycles after the start cycle; lat=0 never completes.
   initial begin
      done_m = 1'b0; q_m = '0; r_m = '0; rem = 0; busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         done_m = 1'b0;
         if (!rst_n) begin
            busy = 1'b0;
         end else if (div_start) begin
            busy = (lat > 0);
            rem  = lat;
            q_m  = div_dividend / div_divisor;
            r_m  = div_dividend % div_divisor;
         end else if (busy) begin
            rem--;
            if (rem == 0) begin
               done_m = 1'b1;
               busy   = 1'b0;
            end
         end
      end
   end

   // Requester driver: head of each queue is presented until accepted.
   initial begin
      logic [N-1:0] acc;
      ent_t e;
      req_valid = '0; req_dividend = '0; req_divisor = '0;
      last_acc_cyc = 0;
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         for (int k = 0; k < N; k++) begin
            if (acc[k] && reqq[k].size() > 0) begin
               e = reqq[k].pop_front();
               e.k = k;
               e.acc = cyc;
               if (!e.lost) sb.push_back(e);
               grant_log.push_back(k);
               last_acc_cyc = cyc;
            end
         end
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if (acc[k] || !req_valid[k]) begin
               if (reqq[k].size() > 0) begin
                  req_valid[k] = 1'b1;
                  req_dividend[k*W +: W] = reqq[k][0].a;
                  req_divisor[k*W +: W]  = reqq[k][0].b;
               end else begin
                  req_valid[k] = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each new response and checks it while held.
   initial begin
      in_rsp = 1'b0; start_cnt = 0; abort_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_rsp = 1'b0;
         end else begin
            if (div_start) begin
               start_cnt++;
               check("start_delay", 64'(cyc - last_acc_cyc), 64'd1);
            end
            if (div_abort) begin
               abort_cnt++;
               check("abort_delay", 64'(cyc - last_acc_cyc), 64'(TO + 1));
            end
            if (rsp_valid != '0) begin
               if (!in_rsp) begin
                  if (sb.size() == 0) begin
                     check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                  end else begin
                     cur = sb.pop_front();
                     in_rsp = 1'b1;
                     if (cur.lat >= 0)
                        check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
                  end
               end
               if (in_rsp) begin
                  check("rsp_valid", 64'(rsp_valid), 64'(1 << cur.k));
                  check("quotient", 64'(rsp_quotient), 64'(cur.q));
                  check("remainder", 64'(rsp_remainder), 64'(cur.r));
                  check("flags", {62'd0, rsp_divzero, rsp_error},
                        {62'd0, cur.dz, cur.er});
                  check("ready_in_resp", 64'(req_ready), 64'd0);
                  if ((rsp_valid & rsp_ready) != '0) in_rsp = 1'b0;
               end
            end
         end
      end
   end

   task automatic check_rst_outs(input string tag);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      check({tag, "_rsp_q_r"}, {rsp_quotient, rsp_remainder}, 64'd0);
      check({tag, "_rsp_flags"}, {62'd0, rsp_divzero, rsp_error}, 64'd0);
      check({tag, "_div_ctl"}, {62'd0, div_start, div_abort}, 64'd0);
      check({tag, "_div_ops"}, {div_dividend, div_divisor}, 64'd0);
   endtask

   task automatic drain(input string tag);
      int t;
      bit idle;
      t = 0;
      idle = 1'b0;
      while (!idle && t < 500) begin
         @(negedge clk);
         t++;
         idle = (req_valid == '0) && (sb.size() == 0) && !in_rsp
              && (rsp_valid == '0);
         for (int k = 0; k < N; k++)
            if (reqq[k].size() > 0) idle = 1'b0;
      end
      if (!idle) check({tag, "_drain_timeout"}, 64'(t), 64'd0);
   endtask

   initial begin
      int s, a, g, t;
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0; rsp_ready = '1; late_done = 1'b0; lat = 33;
      repeat (3) @(negedge clk);
      check_rst_outs("reset");
      rst_n = 1'b1;

      s = start_cnt;
      reqq[0].push_back(mk(100, 7, 14, 2, 0, 0, 35));
      drain("single");
      check("single_starts", 64'(start_cnt - s), 64'd1);

      s = start_cnt;
      reqq[1].push_back(mk(32'h1234, 0, 32'hFFFF_FFFF, 32'h1234, 1, 0, 1));
      drain("divzero");
      check("divzero_no_start", 64'(start_cnt - s), 64'd0);

      lat = 4;
      g = grant_log.size();
      reqq[0].push_back(mk(50, 5, 10, 0, 0, 0, 6));
      reqq[0].push_back(mk(50, 5, 10, 0, 0, 0, 6));
      reqq[1].push_back(mk(9, 4, 2, 1, 0, 0, 6));
      reqq[1].push_back(mk(9, 4, 2, 1, 0, 0, 6));
      drain("rr");
      check("rr_count", 64'(grant_log.size() - g), 64'd4);
      if (grant_log.size() - g == 4)
         check("rr_order", {grant_log[g], grant_log[g+1],
                            grant_log[g+2], grant_log[g+3]},
               {32'd0, 32'd1, 32'd0, 32'd1} & 64'hFFFF_FFFF_FFFF_FFFF);

      lat = 0;
      a = abort_cnt;
      reqq[0].push_back(mk(123, 4, 0, 0, 0, 1, TO + 2));
      t = 0;
      while (abort_cnt == a && t < 300) begin
         @(posedge clk);
         t++;
      end
      check("abort_seen", 64'(abort_cnt - a), 64'd1);
      repeat (5) @(posedge clk);
      #1 late_done = 1'b1;
      @(posedge clk);
      #1 late_done = 1'b0;
      lat = 5;
      reqq[1].push_back(mk(1000, 10, 100, 0, 0, 0, 7));
      drain("timeout");
      check("abort_once", 64'(abort_cnt - a), 64'd1);

      lat = 3;
      @(posedge clk);
      #1 rsp_ready[0] = 1'b0;
      reqq[0].push_back(mk(77, 7, 11, 0, 0, 0, 5));
      t = 0;
      while (!in_rsp && t < 100) begin
         @(posedge clk);
         t++;
      end
      check("bp_resp_seen", 64'(in_rsp), 64'd1);
      reqq[1].push_back(mk(20, 6, 3, 2, 0, 0, 5));
      repeat (10) @(posedge clk);
      #1 rsp_ready[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_next", 64'(req_ready), 64'd2);
      drain("backpressure");

      lat = 40;
      s = start_cnt;
      reqq[1].push_back(mk(500, 5, 100, 0, 0, 0, -1, 1'b1));
      t = 0;
      while (start_cnt == s && t < 50) begin
         @(posedge clk);
         t++;
      end
      check("rst_op_started", 64'(start_cnt - s), 64'd1);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_rst_outs("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      lat = 6;
      reqq[0].push_back(mk(81, 9, 9, 0, 0, 0, 8));
      drain("after_rst");
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one iterative 32-bit divider between NUM_REQ requesters in the RSA decryption datapath, e.g. the modular-reduction and key-setup engines.
- Arbitration is round-robin; each requester uses a valid/ready request/response handshake.
- The block drives the divider's start/operand interface, waits for done, and returns quotient and remainder to the granted requester.
- Handles divide-by-zero locally and recovers from a divider timeout.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
WIDTH, 32, operand and result width
TIMEOUT, 64, max cycles in WAIT before abort (must be >= divider latency + 2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero)
req_dividend  in  NUM_REQ*WIDTH  flattened dividends; requester k uses slice k
req_divisor  in  NUM_REQ*WIDTH  flattened divisors; requester k uses slice k
rsp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero)
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_quotient  out  WIDTH  shared response quotient
rsp_remainder  out  WIDTH  shared response remainder
rsp_divzero  out  1  response is divide-by-zero
rsp_error  out  1  response is a divider timeout
div_start  out  1  one-cycle start pulse to the divider
div_abort  out  1  one-cycle abort pulse to the divider
div_dividend  out  WIDTH  operand to the divider, held from ISSUE to end of WAIT
div_divisor  out  WIDTH  operand to the divider, held from ISSUE to end of WAIT
div_done  in  1  divider result valid, single-cycle pulse
div_quotient  in  WIDTH  divider quotient, sampled when div_done=1
div_remainder  in  WIDTH  divider remainder, sampled when div_done=1

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, rr_ptr=0, grant index=0, timeout counter=0.
  - All outputs 0; operand and result registers 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in IDLE only; all other req_ready bits are 0.
  - Handshake occurs on the edge where req_valid[k] & req_ready[k]. On that edge:
    - Latch the operands and grant index.
    - Set rr_ptr = (k+1) mod NUM_REQ.
  - Divisor==0 on accept: go to RESP. Result: quotient=all ones, remainder=dividend, rsp_divzero=1. The divider is not started.
  - Divisor!=0 on accept: go to ISSUE.
- ISSUE (exactly 1 cycle):
  - div_start=1 with div_dividend/div_divisor valid.
  - Go to WAIT; timeout counter=0.
- WAIT:
  - Counter increments each cycle.
  - div_done=1: latch div_quotient/div_remainder, rsp_divzero=0, rsp_error=0, go to RESP.
  - Counter reaches TIMEOUT-1 without done: div_abort=1 for that cycle; quotient=0, remainder=0, rsp_error=1; go to RESP.
  - If done and timeout coincide, done wins: no abort, no error.
- RESP:
  - rsp_valid[grant]=1; result outputs held stable.
  - Leave to IDLE on the edge where rsp_ready[grant]=1.
  - Request acceptance can resume the following cycle; there are no back-to-back grants in the RESP-exit cycle.
  - rsp_ready bits of other requesters are ignored.
- div_done outside WAIT, including a late done after abort, is ignored.
- No request is accepted outside IDLE; req_ready=0 in ISSUE, WAIT and RESP.
- Latency, accept edge to rsp_valid:
  - Normal: divider latency L (div_start cycle to div_done cycle) + 2 cycles.
  - Divide-by-zero: 1 cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Reset mid-operation (any state): immediate return to reset values; no div_abort is issued; the in-flight result is lost.
- Requesters must hold req_valid and operands stable until accepted. The arbiter must not depend on unaccepted requests staying stable; the winner is re-evaluated every IDLE cycle.

Test Plan:
- Single request, requester 0: 100/7 with a divider model of L=33 → div_start 1 cycle after accept; rsp_valid[0] 35 cycles after accept; quotient=14, remainder=2, flags 0.
- Both requesters valid continuously, rr_ptr=0, ops 50/5 and 9/4 → grant order 0,1,0,1; responses (10,0) to requester 0 and (2,1) to requester 1, each on its own rsp_valid bit only.
- Divide-by-zero: requester 1 sends 0x1234/0 → no div_start; rsp_valid[1] 1 cycle after accept; quotient=0xFFFFFFFF, remainder=0x1234, rsp_divzero=1.
- Timeout: divider model never asserts done, TIMEOUT=64 → div_abort pulse once after 64 WAIT cycles; rsp_error=1, quotient=remainder=0; a late div_done 5 cycles later is ignored and the next request completes normally.
- Response backpressure: hold rsp_ready[0]=0 for 10 cycles → rsp_valid and results stable, req_ready all 0; release → IDLE next cycle.
- rst_n pulsed low during WAIT → all outputs 0 asynchronously; after release a new 81/9 request returns quotient=9, remainder=0.
